pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage ARM core. It detects ID-stage data hazards and EXE-stage taken branches, and sequences multi-cycle SRAM accesses in the MEM stage. From these it drives the freeze/flush controls of the PC, IF/ID, ID/EX, EXE/MEM and MEM/WB registers. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/arm_pipe_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline control logic.
package arm_pipe_pkg;

    localparam int REG_IDX_W     = 4;
    localparam int SRAM_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } sram_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ID-stage data hazard equation; selects full RAW checking or load-use only
// depending on whether the forwarding unit is active.
module hazard_detect
    import arm_pipe_pkg::*;
(
    input  logic                 forward_en_i,
    input  logic [REG_IDX_W-1:0] id_src1_i,
    input  logic [REG_IDX_W-1:0] id_src2_i,
    input  logic                 id_two_src_i,
    input  logic                 id_uses_src1_i,
    input  logic [REG_IDX_W-1:0] exe_dest_i,
    input  logic                 exe_wb_en_i,
    input  logic                 exe_mem_r_en_i,
    input  logic [REG_IDX_W-1:0] mem_dest_i,
    input  logic                 mem_wb_en_i,
    output logic                 hazard_o
);

    logic src1_exe_match;
    logic src2_exe_match;
    logic src1_hit;
    logic src2_hit;
    logic load_use;

    assign src1_exe_match = id_uses_src1_i & (id_src1_i == exe_dest_i);
    assign src2_exe_match = id_two_src_i   & (id_src2_i == exe_dest_i);

    assign src1_hit = id_uses_src1_i &
                      ((exe_wb_en_i & (id_src1_i == exe_dest_i)) |
                       (mem_wb_en_i & (id_src1_i == mem_dest_i)));
    assign src2_hit = id_two_src_i &
                      ((exe_wb_en_i & (id_src2_i == exe_dest_i)) |
                       (mem_wb_en_i & (id_src2_i == mem_dest_i)));

    // With forwarding, only a load in EXE cannot supply its result in time.
    assign load_use = exe_mem_r_en_i & exe_wb_en_i & (src1_exe_match | src2_exe_match);

    assign hazard_o = forward_en_i ? load_use : (src1_hit | src2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: hazard stalls, taken-branch flushes, multi-cycle SRAM
// sequencing in MEM, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int SRAM_WAIT = SRAM_WAIT_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 forward_en,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 id_uses_src1,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 mem_r_en,
    input  logic                 mem_w_en,
    input  logic                 b_taken,
    output logic                 freeze_front,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 freeze_back,
    output logic                 sram_busy,
    output logic                 sram_done,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int                WAIT_W    = (SRAM_WAIT > 2) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((SRAM_WAIT > 0) ? SRAM_WAIT - 1 : 0);
    localparam logic              SRAM_EN   = (SRAM_WAIT > 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    sram_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              mem_req;
    logic              hazard;

    hazard_detect u_hazard_detect (
        .forward_en_i   (forward_en),
        .id_src1_i      (id_src1),
        .id_src2_i      (id_src2),
        .id_two_src_i   (id_two_src),
        .id_uses_src1_i (id_uses_src1),
        .exe_dest_i     (exe_dest),
        .exe_wb_en_i    (exe_wb_en),
        .exe_mem_r_en_i (exe_mem_r_en),
        .mem_dest_i     (mem_dest),
        .mem_wb_en_i    (mem_wb_en),
        .hazard_o       (hazard)
    );

    assign mem_req = mem_r_en | mem_w_en;

    // The IDLE cycle that accepts a request is itself the first frozen cycle,
    // so WAIT covers the remaining SRAM_WAIT-1 cycles before DONE.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals; no latches.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_req && SRAM_EN) begin
                    if (SRAM_WAIT == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q <= WAIT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking for all sequential state, so every register samples pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign freeze_back = ~rst & ((state_q == WAIT) | ((state_q == IDLE) & mem_req & SRAM_EN));
    assign sram_busy   = freeze_back;
    assign sram_done   = ~rst & (state_q == DONE);

    // A frozen back end holds EXE, so a pending branch re-presents on release.
    always_comb begin
        freeze_front = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (rst) begin
            freeze_front = 1'b0;
        end else if (freeze_back) begin
            freeze_front = 1'b1;
        end else if (b_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (hazard) begin
            freeze_front = 1'b1;
            flush_id_ex  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (freeze_front && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_if_id && (flush_cnt_q != CNT_MAX))  flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default build, a 4-bit-counter build
// for saturation, and a single-cycle-memory build.
module tb_pipe_hazard_ctrl;

    // {freeze_front, flush_if_id, flush_id_ex, freeze_back, sram_busy, sram_done}
    localparam logic [5:0] C_NONE       = 6'b000000;
    localparam logic [5:0] C_STALL      = 6'b101000;
    localparam logic [5:0] C_FLUSH      = 6'b011000;
    localparam logic [5:0] C_MEMWAIT    = 6'b100110;
    localparam logic [5:0] C_DONE       = 6'b000001;
    localparam logic [5:0] C_DONE_FLUSH = 6'b011001;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en, id_two_src, id_uses_src1, exe_wb_en, exe_mem_r_en;
    logic       mem_wb_en, mem_r_en, mem_w_en, b_taken;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;

    logic        ff, fi, fe, fb, sb, sd;
    logic [15:0] stall_cnt, flush_cnt;
    logic        c4_ff, c4_fi, c4_fe, c4_fb, c4_sb, c4_sd;
    logic [3:0]  c4_stall_cnt, c4_flush_cnt;
    logic        w0_ff, w0_fi, w0_fe, w0_fb, w0_sb, w0_sd;
    logic [15:0] w0_stall_cnt, w0_flush_cnt;

    logic [5:0] ctrl, c4_ctrl, w0_ctrl;
    assign ctrl    = {ff, fi, fe, fb, sb, sd};
    assign c4_ctrl = {c4_ff, c4_fi, c4_fe, c4_fb, c4_sb, c4_sd};
    assign w0_ctrl = {w0_ff, w0_fi, w0_fe, w0_fb, w0_sb, w0_sd};

    int vectors     = 0;
    int miscompares = 0;
    int exp_stall   = 0;
    int exp_flush   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.SRAM_WAIT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_src1(id_uses_src1), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b_taken(b_taken),
        .freeze_front(ff), .flush_if_id(fi), .flush_id_ex(fe), .freeze_back(fb),
        .sram_busy(sb), .sram_done(sd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.SRAM_WAIT(4), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_src1(id_uses_src1), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b_taken(b_taken),
        .freeze_front(c4_ff), .flush_if_id(c4_fi), .flush_id_ex(c4_fe), .freeze_back(c4_fb),
        .sram_busy(c4_sb), .sram_done(c4_sd), .stall_cnt(c4_stall_cnt), .flush_cnt(c4_flush_cnt)
    );

    pipe_hazard_ctrl #(.SRAM_WAIT(0), .CNT_W(16)) dut_w0 (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_src1(id_uses_src1), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b_taken(b_taken),
        .freeze_front(w0_ff), .flush_if_id(w0_fi), .flush_id_ex(w0_fe), .freeze_back(w0_fb),
        .sram_busy(w0_sb), .sram_done(w0_sd), .stall_cnt(w0_stall_cnt), .flush_cnt(w0_flush_cnt)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        forward_en   = 1'b0;
        id_src1      = 4'd0;
        id_src2      = 4'd0;
        id_two_src   = 1'b0;
        id_uses_src1 = 1'b0;
        exe_dest     = 4'd0;
        exe_wb_en    = 1'b0;
        exe_mem_r_en = 1'b0;
        mem_dest     = 4'd0;
        mem_wb_en    = 1'b0;
        mem_r_en     = 1'b0;
        mem_w_en     = 1'b0;
        b_taken      = 1'b0;
    endtask

    // EXE: ADD r3 ; ID: SUB r5, r3, r1
    task automatic setup_exe_r3_hazard();
        exe_dest     = 4'd3;
        exe_wb_en    = 1'b1;
        id_src1      = 4'd3;
        id_uses_src1 = 1'b1;
        id_src2      = 4'd1;
        id_two_src   = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        setup_exe_r3_hazard();
        mem_r_en = 1'b1;
        b_taken  = 1'b1;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (ctrl !== C_NONE) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want %b", ctrl, C_NONE);
        end
        vectors++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
        end
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (ctrl !== C_NONE) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want %b", ctrl, C_NONE);
        end
    endtask

    task automatic test_hazard_no_forward();
        next_cycle();
        clear_inputs();
        setup_exe_r3_hazard();
        @(negedge clk);
        vectors++;
        if (ctrl !== C_STALL || stall_cnt !== 16'(exp_stall)) begin
            miscompares++;
            $display("FAIL hz_exe_src1: got ctrl=%b stall=%0d want ctrl=%b stall=%0d",
                     ctrl, stall_cnt, C_STALL, exp_stall);
        end
        exp_stall++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (ctrl !== C_NONE || stall_cnt !== 16'(exp_stall)) begin
            miscompares++;
            $display("FAIL hz_exe_release: got ctrl=%b stall=%0d want ctrl=%b stall=%0d",
                     ctrl, stall_cnt, C_NONE, exp_stall);
        end
        // MEM writes r0; ID reads r0 via src2 only.
        next_cycle();
        clear_inputs();
        mem_dest   = 4'd0;
        mem_wb_en  = 1'b1;
        id_src2    = 4'd0;
        id_two_src = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctrl !== C_STALL) begin
            miscompares++;
            $display("FAIL hz_mem_r0_src2: got %b want %b", ctrl, C_STALL);
        end
        exp_stall++;
        next_cycle();
        id_two_src = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctrl !== C_NONE) begin
            miscompares++;
            $display("FAIL hz_gated_src2: got %b want %b", ctrl, C_NONE);
        end
    endtask

    task automatic test_forwarding();
        next_cycle();
        clear_inputs();
        forward_en = 1'b1;
        setup_exe_r3_hazard();
        mem_dest  = 4'd1;
        mem_wb_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctrl !== C_NONE) begin
            miscompares++;
            $display("FAIL fwd_alu_no_stall: got %b want %b", ctrl, C_NONE);
        end
        next_cycle();
        mem_wb_en    = 1'b0;
        exe_mem_r_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctrl !== C_STALL) begin
            miscompares++;
            $display("FAIL fwd_load_use: got %b want %b", ctrl, C_STALL);
        end
        exp_stall++;
        next_cycle();
        clear_inputs();
        forward_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctrl !== C_NONE || stall_cnt !== 16'(exp_stall)) begin
            miscompares++;
            $display("FAIL fwd_one_stall: got ctrl=%b stall=%0d want ctrl=%b stall=%0d",
                     ctrl, stall_cnt, C_NONE, exp_stall);
        end
    endtask

    task automatic test_branch();
        next_cycle();
        clear_inputs();
        setup_exe_r3_hazard();
        b_taken = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctrl !== C_FLUSH || flush_cnt !== 16'(exp_flush)) begin
            miscompares++;
            $display("FAIL br_over_hazard: got ctrl=%b flush=%0d want ctrl=%b flush=%0d",
                     ctrl, flush_cnt, C_FLUSH, exp_flush);
        end
        exp_flush++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
            miscompares++;
            $display("FAIL br_counts: got flush=%0d stall=%0d want flush=%0d stall=%0d",
                     flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
    endtask

    task automatic test_sram_access();
        next_cycle();
        clear_inputs();
        mem_r_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ctrl !== C_MEMWAIT || w0_ctrl !== C_NONE) begin
                miscompares++;
                $display("FAIL sram_wait_c%0d: got ctrl=%b w0=%b want ctrl=%b w0=%b",
                         i, ctrl, w0_ctrl, C_MEMWAIT, C_NONE);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (ctrl !== C_DONE || w0_ctrl !== C_NONE) begin
            miscompares++;
            $display("FAIL sram_done_c5: got ctrl=%b w0=%b want ctrl=%b w0=%b",
                     ctrl, w0_ctrl, C_DONE, C_NONE);
        end
        exp_stall += 4;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (ctrl !== C_NONE || stall_cnt !== 16'(exp_stall)) begin
            miscompares++;
            $display("FAIL sram_after: got ctrl=%b stall=%0d want ctrl=%b stall=%0d",
                     ctrl, stall_cnt, C_NONE, exp_stall);
        end
    endtask

    task automatic test_branch_under_freeze();
        next_cycle();
        clear_inputs();
        mem_w_en = 1'b1;
        b_taken  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ctrl !== C_MEMWAIT || flush_cnt !== 16'(exp_flush)) begin
                miscompares++;
                $display("FAIL brfz_wait_c%0d: got ctrl=%b flush=%0d want ctrl=%b flush=%0d",
                         i, ctrl, flush_cnt, C_MEMWAIT, exp_flush);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (ctrl !== C_DONE_FLUSH) begin
            miscompares++;
            $display("FAIL brfz_release: got %b want %b", ctrl, C_DONE_FLUSH);
        end
        exp_flush++;
        exp_stall += 4;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (ctrl !== C_NONE || flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
            miscompares++;
            $display("FAIL brfz_counts: got ctrl=%b flush=%0d stall=%0d want %b/%0d/%0d",
                     ctrl, flush_cnt, stall_cnt, C_NONE, exp_flush, exp_stall);
        end
    endtask

    task automatic test_reset_mid_access();
        next_cycle();
        clear_inputs();
        mem_r_en = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        vectors++;
        if (fb !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_wait2: got freeze_back=%b want 1", fb);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (ctrl !== C_NONE || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_mid_access: got ctrl=%b stall=%0d flush=%0d want %b/0/0",
                     ctrl, stall_cnt, flush_cnt, C_NONE);
        end
        exp_stall = 0;
        exp_flush = 0;
        next_cycle();
        rst      = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ctrl !== C_MEMWAIT) begin
                miscompares++;
                $display("FAIL rst_rerun_c%0d: got %b want %b", i, ctrl, C_MEMWAIT);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (ctrl !== C_DONE) begin
            miscompares++;
            $display("FAIL rst_rerun_done: got %b want %b", ctrl, C_DONE);
        end
        exp_stall += 4;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin
            miscompares++;
            $display("FAIL rst_rerun_cnt: got stall=%0d flush=%0d want %0d/%0d",
                     stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
    endtask

    task automatic test_saturation();
        next_cycle();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        clear_inputs();
        setup_exe_r3_hazard();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 16 || i == 19) begin
                vectors++;
                if (c4_stall_cnt !== 4'd15 || c4_ctrl !== C_STALL) begin
                    miscompares++;
                    $display("FAIL sat_c%0d: got cnt=%0d ctrl=%b want cnt=15 ctrl=%b",
                             i, c4_stall_cnt, c4_ctrl, C_STALL);
                end
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (c4_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
            miscompares++;
            $display("FAIL sat_final: got c4=%0d wide=%0d want 15/20", c4_stall_cnt, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_hazard_no_forward();
        test_forwarding();
        test_branch();
        test_sram_access();
        test_branch_under_freeze();
        test_reset_mid_access();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
